// File: rtl/seq_divider_8by4_pkg.sv
// Shared definitions for the 8-by-4 sequential restoring divider.
// Optional zero-divisor short cut: SEQDIV_ZERO_DETECT_EN.
package seqdiv_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int CNT_W = $clog2(DVD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Handshake/operand bus of the sequential divider.
// div_err exists only when SEQDIV_ZERO_DETECT_EN is defined.
interface seq_divider_8by4_if;
    import seqdiv_pkg::*;

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
`ifdef SEQDIV_ZERO_DETECT_EN
    logic             div_err;

    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_err);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_err);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder);
`endif

endinterface

// File: rtl/seq_divider_8by4_div_sub_stage.sv
// One restoring-division step: trial subtract T - divisor with a ripple of
// full-adder cells; ge is the no-borrow carry-out, R is either the
// difference or T restored. Also holds the Full_Adder/NOT gate cells.

module NOT (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule

module Full_Adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module div_sub_stage
    import seqdiv_pkg::*;
(
    input  logic [DVS_W:0]   i_t,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_ge,
    output logic [DVS_W-1:0] o_r
);
    logic [DVS_W-1:0] w_dvs_n;
    logic [DVS_W-1:0] w_diff;
    logic [DVS_W:0]   w_carry;

    // Two's-complement subtract: T + ~divisor + 1.
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < DVS_W; g++) begin : g_bit
        NOT u_not (
            .i_a (i_divisor[g]),
            .o_y (w_dvs_n[g])
        );
        Full_Adder u_fa (
            .i_a    (i_t[g]),
            .i_b    (w_dvs_n[g]),
            .i_cin  (w_carry[g]),
            .o_s    (w_diff[g]),
            .o_cout (w_carry[g+1])
        );
    end

    // The subtrahend MSB is always 0 (inverted to 1), so the top stage reduces
    // to a carry of t_msb | c_in; its sum bit is never needed because a
    // successful subtract always fits in DVS_W bits (or equals T when divisor=0,
    // where T is truncated anyway).
    assign o_ge = i_t[DVS_W] | w_carry[DVS_W];

    // Keep the difference on success, otherwise restore T.
    always_comb begin
        o_r = o_ge ? w_diff : i_t[DVS_W-1:0];
    end

endmodule

// File: rtl/seq_divider_8by4.sv
// Iterative restoring divider, 8-bit dividend by 4-bit divisor, one quotient
// bit per clock, MSB first, start/busy/done handshake.
// Optional SEQDIV_ZERO_DETECT_EN: divisor 0 skips RUN and raises div_err.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepted edge
//   RUN   | one restoring step per clock, r_cnt = dividend bit index
//   DONE  | one-cycle done pulse, results valid from here on
module seq_divider_8by4
    import seqdiv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    seq_divider_8by4_if.slave  bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W-1:0] r_rem;
    logic [DVD_W-1:0] r_qsr;
    logic [CNT_W-1:0] r_cnt;
    logic [DVD_W-1:0] r_quot;
    logic [DVS_W-1:0] r_remout;
    logic [DVS_W:0]   w_t;
    logic             w_ge;
    logic [DVS_W-1:0] w_r_nxt;
    logic             w_skip;
`ifdef SEQDIV_ZERO_DETECT_EN
    logic             r_err;
`endif

    assign w_t = {r_rem, r_dvd[r_cnt]};

    div_sub_stage u_sub (
        .i_t       (w_t),
        .i_divisor (r_dvs),
        .o_ge      (w_ge),
        .o_r       (w_r_nxt)
    );

`ifdef SEQDIV_ZERO_DETECT_EN
    assign w_skip = (bus.divisor == '0);
`else
    assign w_skip = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_skip ? DONE : RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.busy = (r_state != IDLE);
        bus.done = (r_state == DONE);
    end

    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remout;
`ifdef SEQDIV_ZERO_DETECT_EN
    assign bus.div_err   = r_err;
`endif

    // Operand capture, per-step shift/subtract and result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_qsr    <= '0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_remout <= '0;
`ifdef SEQDIV_ZERO_DETECT_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd <= bus.dividend;
                        r_dvs <= bus.divisor;
                        r_rem <= '0;
                        r_qsr <= '0;
                        r_cnt <= CNT_W'(DVD_W - 1);
`ifdef SEQDIV_ZERO_DETECT_EN
                        r_err <= w_skip;
                        // Same values the full iteration would reach with divisor 0.
                        if (w_skip) begin
                            r_quot   <= '1;
                            r_remout <= bus.dividend[DVS_W-1:0];
                        end
`endif
                    end
                end
                RUN: begin
                    r_rem <= w_r_nxt;
                    r_qsr <= {r_qsr[DVD_W-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_quot   <= {r_qsr[DVD_W-2:0], w_ge};
                        r_remout <= w_r_nxt;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed bench for seq_divider_8by4 with hand-computed expected values.
// Handles both builds of SEQDIV_ZERO_DETECT_EN.
module tb_seq_divider_8by4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   lat;
    int   busy_n;
    int   cnt;

    seq_divider_8by4_if bus ();

    seq_divider_8by4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one accepted edge, then scramble inputs.
    task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    // lat = negedges after the accept edge until done (0 = cycle right after it).
    task automatic wait_done(output int l, output int b);
        l = 0;
        @(negedge clk);
        b = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && l < 30) begin
            @(negedge clk);
            l++;
            if (bus.busy === 1'b1) b++;
        end
        check("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                          input logic [7:0] eq, input logic [3:0] er, input int elat,
                          input logic eerr);
        int l, b;
        start_op(dvd, dvs);
        wait_done(l, b);
        check({tag, "_lat"}, 32'(l), 32'(elat));
        check({tag, "_busy"}, 32'(b), 32'(elat + 1));
        check({tag, "_q"}, {24'd0, bus.quotient}, {24'd0, eq});
        check({tag, "_r"}, {28'd0, bus.remainder}, {28'd0, er});
`ifdef SEQDIV_ZERO_DETECT_EN
        check({tag, "_err"}, {31'd0, bus.div_err}, {31'd0, eerr});
`else
        if (eerr) $display("note: %s divide-by-zero has no error flag in this build", tag);
`endif
        @(negedge clk);
        check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q", {24'd0, bus.quotient}, 32'd0);
        check("rst_r", {28'd0, bus.remainder}, 32'd0);
`ifdef SEQDIV_ZERO_DETECT_EN
        check("rst_err", {31'd0, bus.div_err}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op("d200_7",  8'd200, 4'd7,  8'd28, 4'd4, 8, 1'b0);
        run_op("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 8, 1'b0);
        run_op("d5_9",    8'd5,   4'd9,  8'd0,  4'd5, 8, 1'b0);
        run_op("d0_1",    8'd0,   4'd1,  8'd0,  4'd0, 8, 1'b0);
`ifdef SEQDIV_ZERO_DETECT_EN
        run_op("dA5_0",   8'hA5,  4'd0,  8'hFF, 4'd5, 0, 1'b1);
        run_op("d77_6_clr", 8'd77, 4'd6, 8'd12, 4'd5, 8, 1'b0);
`else
        run_op("dA5_0",   8'hA5,  4'd0,  8'hFF, 4'd5, 8, 1'b0);
`endif

        // start pulsed mid-RUN with other operands must be ignored
        start_op(8'd100, 4'd3);
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd7;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(lat, busy_n);
        check("ign_q", {24'd0, bus.quotient}, 32'd33);
        check("ign_r", {28'd0, bus.remainder}, 32'd1);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        check("ign_no_second", 32'(cnt), 32'd0);

        // start held high: back-to-back, one result per 10 cycles
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < 40);
        check("b2b_first_lat", 32'(lat), 32'd9);
        check("b2b_first_q", {24'd0, bus.quotient}, 32'd28);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < 40);
        check("b2b_period", 32'(lat), 32'd10);
        check("b2b_second_q", {24'd0, bus.quotient}, 32'd28);
        check("b2b_second_r", {28'd0, bus.remainder}, 32'd4);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_idle", {31'd0, bus.busy}, 32'd0);

        // async reset at RUN step 4
        start_op(8'd200, 4'd7);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_q", {24'd0, bus.quotient}, 32'd0);
        check("mid_rst_r", {28'd0, bus.remainder}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        check("mid_rst_no_done", 32'(cnt), 32'd0);
        run_op("d77_6", 8'd77, 4'd6, 8'd12, 4'd5, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider_8by4.md
Name: seq_divider_8by4

Overview:
- Iterative restoring divider that computes the inverse operation of the 4-bit array multiplier.
- Divides an 8-bit dividend by a 4-bit divisor, giving an 8-bit quotient and a 4-bit remainder.
- Produces one quotient bit per clock and uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic lab datapath as its sequential counterpart.

Parameters:
- DVD_W, 8, dividend and quotient width.
- DVS_W, 4, divisor and remainder width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  DVD_W  numerator, captured on the accepted start edge.
- divisor  input  DVS_W  denominator, captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; quotient and remainder are valid from this cycle.
- quotient  output  DVD_W  registered result, held until the next accepted start.
- remainder  output  DVS_W  registered result, held until the next accepted start.
- div_err  output  1  divide-by-zero flag; exists only with SEQDIV_ZERO_DETECT_EN.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_err=0, step counter=0.
- States and transitions:
  - IDLE: start=1 captures operands, clears the partial remainder R (DVS_W bits) and the quotient shift register, sets cnt=DVD_W-1, goes to RUN.
  - IDLE with start=0: stays in IDLE.
  - RUN: one step per edge, MSB first.
    - T = {R, dvd[cnt]} (DVS_W+1 bits).
    - If T >= {1'b0,divisor}: R = (T - divisor)[DVS_W-1:0] and q bit = 1.
    - Else: R = T[DVS_W-1:0] and q bit = 0.
    - After the step with cnt==0, load quotient/remainder and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+DVD_W (9 edges for the default widths).
- Throughput: one division per DVD_W+2 cycles.
- start while busy (RUN or DONE): ignored; it has no effect on the operation in flight.
- Inputs may change freely after the start edge, because the operands are captured.
- Divisor 0 with the algorithm only: every step subtracts 0, so quotient=all ones (0xFF) and remainder=dividend[DVS_W-1:0] (T is truncated to DVS_W bits).
- Reset mid-RUN: the operation is abandoned, outputs go to their reset values, and no done is issued.
- The compare/subtract is unsigned only; there is no signed mode.

Optional Feature:
- Macro: SEQDIV_ZERO_DETECT_EN.
- Defined:
  - The div_err port exists.
  - When divisor==0 at the start edge, the block skips RUN and goes IDLE->DONE.
  - In that case done is high in the cycle after the start edge, with quotient=all ones, remainder=dividend[DVS_W-1:0] and div_err=1.
  - div_err is cleared on the next accepted start.
- Undefined:
  - There is no div_err port.
  - Divisor 0 runs the full DVD_W steps and gives the same quotient/remainder values as above.

Decomposition:
- Shared package seqdiv_pkg:
  - DVD_W and DVS_W defaults.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width, $clog2(DVD_W).
- Sub-module div_sub_stage (combinational):
  - Inputs: the (DVS_W+1)-bit T and the divisor.
  - Outputs: the ge flag and the restored/subtracted DVS_W-bit R.
  - Built as a ripple subtractor from the team's Full_Adder/NOT gate cells, with ge = carry-out.

Test Plan:
- Reset release, then dividend=200, divisor=7, start one cycle -> done 9 cycles later, quotient=28, remainder=4, busy high for 9 cycles.
- dividend=255, divisor=15 -> quotient=17, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Then dividend=0, divisor=1 -> quotient=0, remainder=0.
- dividend=0xA5, divisor=0 -> quotient=0xFF, remainder=5.
  - With SEQDIV_ZERO_DETECT_EN: done 1 cycle after start, div_err=1.
  - Without it: done after 9 cycles and there is no error flag.
- start pulsed during RUN with different operands -> the first result (100/3 -> 33 r1) is unaffected and no second done appears; start=1 held continuously -> back-to-back operations, one per 10 cycles.
- rst asserted at RUN step 4 -> outputs 0 immediately with no done; a new start of 77/6 afterwards -> quotient=12, remainder=5.
